// File: rtl/board_render_pkg.sv
// Shared constants, types and FSM states for the board-to-LED-matrix renderer.
package board_render_pkg;

  localparam int BOARD_ROWS       = 6;
  localparam int BOARD_COLS       = 7;
  localparam int MATRIX_DIM       = 16;
  localparam int CELL_SIZE        = 2;
  localparam int BOARD_COL_OFFSET = 1;
  localparam int CURSOR_ROW       = 0;

  typedef logic [BOARD_ROWS-1:0][BOARD_COLS-1:0] board_t;
  typedef logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] frame_t;

  typedef enum logic [1:0] {
    SNAP   = 2'd0,
    RENDER = 2'd1,
    SWAP   = 2'd2,
    GAP    = 2'd3
  } render_state_t;

endpackage

// File: rtl/board_frame_renderer_blink.sv
// Frame-counted cursor blink: visible for the first half of every BLINK_FRAMES period.
module frame_blink_counter #(
  parameter int BLINK_FRAMES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  output logic cursorVis
);

  localparam int CW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] blink_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_reg <= '0;
    end else if (frame_tick) begin
      blink_cnt_reg <= (blink_cnt_reg == CW'(BLINK_FRAMES - 1)) ? '0 : blink_cnt_reg + 1'b1;
    end
  end

  assign cursorVis = (blink_cnt_reg < CW'(BLINK_FRAMES / 2));

endmodule

// File: rtl/board_frame_renderer.sv
// Renders snapshotted game state into a double-buffered 16x16 red/green frame, one row per clock.
module board_frame_renderer
  import board_render_pkg::*;
#(
  parameter int FRAME_GAP    = 0,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0][6:0]      board0,
  input  logic [5:0][6:0]      board1,
  input  logic [2:0]           position,
  input  logic                 currentPlayer,
  input  logic                 weHaveAWinner,
  output logic [15:0][15:0]    RedPixels,
  output logic [15:0][15:0]    GrnPixels,
  output logic                 frameDone
);

  render_state_t state_reg;
  logic [3:0]    row_cnt_reg;
  logic [7:0]    gap_cnt_reg;
  board_t        board0_snap_reg, board1_snap_reg;
  logic [2:0]    pos_snap_reg;
  logic          player_snap_reg, win_snap_reg, cursor_vis_snap_reg;
  frame_t        back_red_reg, back_grn_reg;

  logic          cursor_vis;
  logic          frame_tick;

  assign frame_tick = (state_reg == SWAP);

  frame_blink_counter #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .cursorVis  (cursor_vis)
  );

  // Matrix row 15 is the bottom board row, so index the board by the flipped row number.
  logic [3:0]  flip_row;
  logic [2:0]  board_row;
  logic        row_on_board, cursor_rows;
  logic [6:0]  cell0, cell1;
  logic [15:0] cell_red_cols, cell_grn_cols, cursor_cols;
  logic [15:0] overlay, red_row, grn_row;

  assign flip_row     = 4'(MATRIX_DIM - 1) - row_cnt_reg;
  assign board_row    = 3'(flip_row >> 1);
  assign row_on_board = flip_row < 4'(BOARD_ROWS * CELL_SIZE);
  assign cursor_rows  = row_cnt_reg < 4'(CURSOR_ROW + CELL_SIZE);
  assign cell0        = row_on_board ? board0_snap_reg[board_row] : '0;
  assign cell1        = row_on_board ? board1_snap_reg[board_row] : '0;

  assign cell_red_cols[0]            = 1'b0;
  assign cell_red_cols[MATRIX_DIM-1] = 1'b0;
  assign cell_grn_cols[0]            = 1'b0;
  assign cell_grn_cols[MATRIX_DIM-1] = 1'b0;
  assign cursor_cols[0]              = 1'b0;
  assign cursor_cols[MATRIX_DIM-1]   = 1'b0;

  generate
    for (genvar gi = 0; gi < BOARD_COLS; gi++) begin : g_cols
      assign cell_red_cols[CELL_SIZE*gi+BOARD_COL_OFFSET +: CELL_SIZE] = {CELL_SIZE{cell0[gi]}};
      assign cell_grn_cols[CELL_SIZE*gi+BOARD_COL_OFFSET +: CELL_SIZE] = {CELL_SIZE{cell1[gi]}};
      assign cursor_cols[CELL_SIZE*gi+BOARD_COL_OFFSET +: CELL_SIZE] =
        {CELL_SIZE{pos_snap_reg == 3'(gi)}};
    end
  endgenerate

  // Win border replaces the cursor; both take the colour of the player to move.
  assign overlay = ((cursor_rows && cursor_vis_snap_reg && !win_snap_reg) ? cursor_cols : 16'h0000)
                 | (win_snap_reg ? 16'h8001 : 16'h0000);
  assign red_row = cell_red_cols | (player_snap_reg ? 16'h0000 : overlay);
  assign grn_row = cell_grn_cols | (player_snap_reg ? overlay : 16'h0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= SNAP;
      row_cnt_reg         <= '0;
      gap_cnt_reg         <= '0;
      board0_snap_reg     <= '0;
      board1_snap_reg     <= '0;
      pos_snap_reg        <= 3'd7;
      player_snap_reg     <= 1'b0;
      win_snap_reg        <= 1'b0;
      cursor_vis_snap_reg <= 1'b0;
      back_red_reg        <= '0;
      back_grn_reg        <= '0;
      RedPixels           <= '0;
      GrnPixels           <= '0;
      frameDone           <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      case (state_reg)
        SNAP: begin
          board0_snap_reg     <= board0;
          board1_snap_reg     <= board1;
          pos_snap_reg        <= position;
          player_snap_reg     <= currentPlayer;
          win_snap_reg        <= weHaveAWinner;
          cursor_vis_snap_reg <= cursor_vis;
          row_cnt_reg         <= '0;
          state_reg           <= RENDER;
        end
        RENDER: begin
          back_red_reg[row_cnt_reg] <= red_row;
          back_grn_reg[row_cnt_reg] <= grn_row;
          row_cnt_reg               <= row_cnt_reg + 1'b1;
          if (row_cnt_reg == 4'(MATRIX_DIM - 1)) state_reg <= SWAP;
        end
        SWAP: begin
          RedPixels   <= back_red_reg;
          GrnPixels   <= back_grn_reg;
          frameDone   <= 1'b1;
          gap_cnt_reg <= '0;
          state_reg   <= (FRAME_GAP > 0) ? GAP : SNAP;
        end
        GAP: begin
          gap_cnt_reg <= gap_cnt_reg + 1'b1;
          if (gap_cnt_reg == 8'(FRAME_GAP - 1)) state_reg <= SNAP;
        end
        default: state_reg <= SNAP;
      endcase
    end
  end

endmodule

// File: tb/tb_board_frame_renderer.sv
// Directed bench: reset, cell mapping, blink, winner border, snapshot stability, gap/reset timing.
module tb_board_frame_renderer;
  import board_render_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_gap;
  board_t      board0, board1;
  logic [2:0]  position;
  logic        currentPlayer, weHaveAWinner;
  frame_t      red, grn, red_g, grn_g;
  logic        done, done_g;

  int n_checks = 0;
  int n_errors = 0;
  frame_t exp_red, exp_grn;
  int n;

  board_frame_renderer #(.FRAME_GAP(0), .BLINK_FRAMES(64)) dut (
    .clk(clk), .reset(reset), .board0(board0), .board1(board1),
    .position(position), .currentPlayer(currentPlayer), .weHaveAWinner(weHaveAWinner),
    .RedPixels(red), .GrnPixels(grn), .frameDone(done)
  );

  board_frame_renderer #(.FRAME_GAP(10), .BLINK_FRAMES(64)) dut_gap (
    .clk(clk), .reset(reset_gap), .board0(board0), .board1(board1),
    .position(position), .currentPlayer(currentPlayer), .weHaveAWinner(weHaveAWinner),
    .RedPixels(red_g), .GrnPixels(grn_g), .frameDone(done_g)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("check %s ok", tag);
    end
  endtask

  // Counts negedges until the selected frameDone is seen (bounded).
  task automatic wait_done(input bit use_gap, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (((use_gap ? done_g : done) !== 1'b1) && cnt < 200);
  endtask

  task automatic check_frame(input string tag, input bit use_gap);
    check({tag, "_red"}, use_gap ? red_g : red, exp_red);
    check({tag, "_grn"}, use_gap ? grn_g : grn, exp_grn);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset_gap = 1'b1;
    board0 = '0; board1 = '0; position = 3'd7;
    currentPlayer = 1'b0; weHaveAWinner = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_red", red, '0);
    check("rst_grn", grn, '0);
    check("rst_done", 256'(done), 256'(0));
    reset = 1'b0;

    // Blank frames and frame period
    exp_red = '0; exp_grn = '0;
    wait_done(0, n);
    check("first_done", 256'(n), 256'(18));
    check_frame("blank0", 0);
    wait_done(0, n);
    check("period0", 256'(n), 256'(18));
    check_frame("blank1", 0);

    // Cell mapping: bottom-left red, top-right green
    board0[0][0] = 1'b1;
    board1[5][6] = 1'b1;
    wait_done(0, n);
    check("period1", 256'(n), 256'(18));
    exp_red = '0; exp_grn = '0;
    exp_red[14] = 16'h0006; exp_red[15] = 16'h0006;
    exp_grn[4]  = 16'h6000; exp_grn[5]  = 16'h6000;
    check_frame("cells", 0);

    // Snapshot stability: board0 toggles every cycle after SNAP
    board1 = '0;
    board0 = '0; board0[2] = 7'h7F;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i % 2 == 0) board0 = '1;
      else begin board0 = '0; board0[2] = 7'h7F; end
    end
    wait_done(0, n);
    check("snap_done", 256'(n), 256'(1));
    exp_red = '0; exp_grn = '0;
    exp_red[10] = 16'h7FFE; exp_red[11] = 16'h7FFE;
    check_frame("snap", 0);
    board0 = '0;

    // Cursor blink from a fresh reset
    reset = 1'b1;
    position = 3'd3; currentPlayer = 1'b1; weHaveAWinner = 1'b0;
    repeat (5) @(negedge clk);
    check("rst2_red", red, '0);
    reset = 1'b0;
    for (int k = 0; k <= 64; k++) begin
      wait_done(0, n);
      check($sformatf("blink_per%0d", k), 256'(n), 256'(18));
      exp_red = '0; exp_grn = '0;
      if (k < 32 || k >= 64) begin
        exp_grn[0] = 16'h0180; exp_grn[1] = 16'h0180;
      end
      check_frame($sformatf("blink%0d", k), 0);
    end

    // Winner border, steady, cursor suppressed
    weHaveAWinner = 1'b1; currentPlayer = 1'b0; position = 3'd2;
    wait_done(0, n);
    exp_red = '0; exp_grn = '0;
    for (int r = 0; r < 16; r++) exp_red[r] = 16'h8001;
    for (int k = 0; k < 70; k++) begin
      wait_done(0, n);
      check($sformatf("win_per%0d", k), 256'(n), 256'(18));
      check_frame($sformatf("win%0d", k), 0);
    end

    // Gap instance: period, reset mid-render
    weHaveAWinner = 1'b0; position = 3'd7; currentPlayer = 1'b0;
    board0 = '0; board0[0][0] = 1'b1; board1 = '0;
    reset_gap = 1'b0;
    exp_red = '0; exp_grn = '0;
    exp_red[14] = 16'h0006; exp_red[15] = 16'h0006;
    wait_done(1, n);
    check("gap_first", 256'(n), 256'(18));
    check_frame("gap0", 1);
    repeat (19) @(negedge clk);
    reset_gap = 1'b1;
    @(negedge clk);
    check("gaprst_red", red_g, '0);
    check("gaprst_grn", grn_g, '0);
    check("gaprst_done", 256'(done_g), 256'(0));
    reset_gap = 1'b0;
    wait_done(1, n);
    check("gap_after_rst", 256'(n), 256'(18));
    check_frame("gap1", 1);
    wait_done(1, n);
    check("gap_period", 256'(n), 256'(28));
    check_frame("gap2", 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/board_frame_renderer.md
Name: board_frame_renderer

Overview:
- Downstream of the game top level: consumes the two player occupancy boards, cursor column, current player and win flag.
- Renders them into a 16x16 red/green LED-matrix frame for the existing LED matrix driver.
- Renders one matrix row per clock into a back buffer, then swaps to the front buffer, so the displayed frame never tears mid-move.
- Also owns cursor blinking, which is frame-counted.

Parameters:
- FRAME_GAP, 0: idle cycles inserted between SWAP and the next SNAP (0..255).
- BLINK_FRAMES, 64: cursor blink period in frames; cursor visible for the first BLINK_FRAMES/2 frames of each period (even, >=2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- board0  in  [5:0][6:0]  player-0 occupancy, [row][col]; row 0 = bottom board row, col 0 = leftmost
- board1  in  [5:0][6:0]  player-1 occupancy, same indexing
- position  in  3  cursor column 0..6; 7 = no cursor
- currentPlayer  in  1  player to move (0 = red, 1 = green)
- weHaveAWinner  in  1  game won by currentPlayer
- RedPixels  out  [15:0][15:0]  front buffer red, [matrixRow][matrixCol]; row 0 = top, col 0 = left
- GrnPixels  out  [15:0][15:0]  front buffer green
- frameDone  out  1  one-cycle pulse, high in the first cycle a new front buffer is visible

Behaviour:
- Reset (sync, active-high, wins over everything):
  - RedPixels/GrnPixels = 0, frameDone = 0
  - state = SNAP; rowCnt, gapCnt, blinkCnt = 0; back buffers = 0
- Reset mid-frame: the partial back buffer is discarded, front cleared, frame restarts at SNAP.
- SNAP, 1 cycle:
  - Register board0, board1, position, currentPlayer, weHaveAWinner.
  - Register cursorVis = (blinkCnt < BLINK_FRAMES/2).
  - All rendering of this frame uses only these snapshots; input changes after SNAP do not affect the frame. Go to RENDER, rowCnt = 0.
- RENDER, 16 cycles:
  - Each cycle writes back-buffer row rowCnt (red and green, 16 bits each); rowCnt increments.
  - After row 15, go to SWAP.
- SWAP, 1 cycle:
  - On the SWAP edge, front <= back and frameDone <= 1 (registered, high for exactly the next cycle).
  - blinkCnt <= (blinkCnt == BLINK_FRAMES-1) ? 0 : blinkCnt+1.
  - Go to GAP if FRAME_GAP > 0 (gapCnt counts 0..FRAME_GAP-1), else SNAP.
- Frame period = 18 + FRAME_GAP cycles. The first front buffer appears on the 18th edge after reset deasserts.
- Pixel mapping, per matrix row R (evaluated in RENDER):
  - Board cell (r,c) covers rows 14-2r and 15-2r, cols 1+2c and 2+2c.
  - board0 bit sets red; board1 bit sets green; both set gives both channels (amber, illegal upstream, rendered not masked).
  - Cursor covers rows 0..1, cols 1+2p and 2+2p. Drawn only if position <= 6, cursorVis = 1 and weHaveAWinner = 0; colour = currentPlayer's channel.
  - Winner: if weHaveAWinner, cols 0 and 15 of all 16 rows are lit steady in currentPlayer's colour, and the cursor is suppressed.
  - All other pixels (rows 2..3, col 0/15 without a win) are 0.
- position = 7: no cursor pixels; no error.
- Inputs changing every cycle: no effect beyond the SNAP sample.

Decomposition:
- Package board_render_pkg:
  - constants BOARD_ROWS=6, BOARD_COLS=7, MATRIX_DIM=16, CELL_SIZE=2, BOARD_COL_OFFSET=1, CURSOR_ROW=0
  - typedef board_t (logic [5:0][6:0]), typedef frame_t (logic [15:0][15:0])
  - enum render_state_t {SNAP, RENDER, SWAP, GAP}
- One sub-module: frame_blink_counter. Input: frame-tick. Output: cursorVis. Parameter: BLINK_FRAMES.

Test Plan:
- Reset held 5 cycles, released; defaults, all inputs 0, position = 7 -> Red/Grn all 0 throughout; frameDone first high 18 cycles after release, then every 18 cycles.
- board0[0][0]=1, board1[5][6]=1, position=7 -> after next frameDone: Red rows14/15 cols1/2 set; Grn rows4/5 cols13/14 set; every other bit 0.
- position=3, currentPlayer=1, no win -> Grn rows0/1 cols7/8 set for frames 0..31 after reset, clear for frames 32..63, set again at frame 64; Red rows0/1 stay 0.
- weHaveAWinner=1, currentPlayer=0, position=2 -> Red cols0 and 15 set in all 16 rows, steady across 70 frames; rows0/1 cols5/6 clear.
- board0 toggled every cycle during RENDER -> front buffer equals the value sampled in SNAP; no mixed-row frame.
- FRAME_GAP=10; reset asserted at RENDER row 8 -> outputs 0 next cycle; first frameDone 18 cycles after release; subsequent frameDone pulses 28 cycles apart.
